// File: rtl/counter_req_arbiter.sv
// counter_req_arbiter: latches one-shot step requests from several sources
// and issues them round-robin as spaced single-step pulses to the counter.
module counter_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int GAP_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] dir,
    output logic            pulse,
    output logic            uphdl,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] pend,
    output logic [NREQ-1:0] drop,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] GAP_V = 8'(GAP_CYC);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]   sel_q, sel_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      gap_q, gap_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] dir_q, dir_d;
    logic [NREQ-1:0] drop_q, drop_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            pulse_q, pulse_d;
    logic            uphdl_q, uphdl_d;
    logic            busy_q, busy_d;

    logic            hit;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx_v;
    int              idx;

    // Round-robin search: first pending source after the last served one
    always_comb begin
        hit   = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        idx_v = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(rr_ptr_q) + k) % NREQ;
            idx_v = PW'(idx);
            if (!hit && pend_q[idx_v]) begin
                hit  = 1'b1;
                pick = idx_v;
            end
        end
    end

    // Request capture: a request arriving with its own grant re-arms instead of dropping
    always_comb begin
        pend_d = pend_q;
        dir_d  = dir_q;
        drop_d = drop_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                pend_d[i] = 1'b0;
            end
            if (req[i]) begin
                if (!pend_q[i] || grant_q[i]) begin
                    pend_d[i] = 1'b1;
                    dir_d[i]  = dir[i];
                end else begin
                    drop_d[i] = 1'b1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one issue cycle, then the spacing gap
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = (GAP_CYC > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Selection, pointer and gap counter; sel is frozen until the next decision
    always_comb begin
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        gap_d    = gap_q;
        if (state_q == IDLE && hit) begin
            sel_d = pick;
        end
        if (state_q == ISSUE) begin
            rr_ptr_d = sel_q;
            gap_d    = GAP_V;
        end
        if (state_q == GAP) begin
            gap_d = gap_q - 8'd1;
        end
    end

    // FSM outputs, computed from the next state so they register in step with it
    always_comb begin
        pulse_d = (state_d == ISSUE);
        uphdl_d = pulse_d & dir_q[sel_d];
        busy_d  = (state_d != IDLE);
        grant_d = '0;
        if (pulse_d) begin
            grant_d[sel_d] = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= '0;
            rr_ptr_q <= PTR_RST;
            gap_q    <= '0;
            pend_q   <= '0;
            dir_q    <= '0;
            drop_q   <= '0;
            grant_q  <= '0;
            pulse_q  <= 1'b0;
            uphdl_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            drop_q   <= drop_d;
            grant_q  <= grant_d;
            pulse_q  <= pulse_d;
            uphdl_q  <= uphdl_d;
            busy_q   <= busy_d;
        end
    end

    assign pulse = pulse_q;
    assign uphdl = uphdl_q;
    assign grant = grant_q;
    assign pend  = pend_q;
    assign drop  = drop_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_counter_req_arbiter.sv
// tb_counter_req_arbiter: two instances (gap 3 and gap 0) driven with the same
// directed and random requests, checked against a time-based reference model.
module tb_counter_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] dir;

    logic       pulse_w [2];
    logic       uphdl_w [2];
    logic       busy_w  [2];
    logic [3:0] grant_w [2];
    logic [3:0] pend_w  [2];
    logic [3:0] drop_w  [2];

    always #5 clk = ~clk;

    counter_req_arbiter #(.NREQ(4), .GAP_CYC(3)) u0 (
        .clk(clk), .rst(rst), .req(req), .dir(dir),
        .pulse(pulse_w[0]), .uphdl(uphdl_w[0]), .grant(grant_w[0]),
        .pend(pend_w[0]), .drop(drop_w[0]), .busy(busy_w[0])
    );

    counter_req_arbiter #(.NREQ(4), .GAP_CYC(0)) u1 (
        .clk(clk), .rst(rst), .req(req), .dir(dir),
        .pulse(pulse_w[1]), .uphdl(uphdl_w[1]), .grant(grant_w[1]),
        .pend(pend_w[1]), .drop(drop_w[1]), .busy(busy_w[1])
    );

    // Stand-in for the 16-bit up/down counter fed by each instance
    logic [15:0] d_ctr [2];
    logic        ctr_clr;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ctr_clr) d_ctr[k] <= 16'd0;
            else if (pulse_w[k]) d_ctr[k] <= uphdl_w[k] ? d_ctr[k] + 16'd1 : d_ctr[k] - 16'd1;
        end
    end

    // Reference model: pending set, last-served pointer, and the cycle
    // at which each instance is next free to make a decision
    logic [3:0]  m_pend  [2];
    logic [3:0]  m_dir   [2];
    logic [3:0]  m_drop  [2];
    logic [3:0]  m_grant [2];
    logic        m_pulse [2];
    logic        m_uphdl [2];
    logic        m_busy  [2];
    logic [15:0] m_ctr   [2];
    int          m_ptr   [2];
    int          m_ready [2];

    int cyc;
    int checks;
    int errors;

    function automatic int gap_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = '0;
            m_dir[k]   = '0;
            m_drop[k]  = '0;
            m_grant[k] = '0;
            m_pulse[k] = 1'b0;
            m_uphdl[k] = 1'b0;
            m_busy[k]  = 1'b0;
            m_ctr[k]   = 16'd0;
            m_ptr[k]   = 3;
            m_ready[k] = cyc;
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] d);
        logic [3:0] gv, np, nd, ndr;
        logic [1:0] ix;
        int         sel;
        for (int k = 0; k < 2; k++) begin
            gv  = m_pulse[k] ? m_grant[k] : 4'b0;
            np  = m_pend[k];
            nd  = m_dir[k];
            ndr = m_drop[k];
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    if (!m_pend[k][i] || gv[i]) begin
                        np[i] = 1'b1;
                        nd[i] = d[i];
                    end else begin
                        ndr[i] = 1'b1;
                    end
                end else if (gv[i]) begin
                    np[i] = 1'b0;
                end
            end
            if (m_pulse[k]) m_ctr[k] = m_uphdl[k] ? m_ctr[k] + 16'd1 : m_ctr[k] - 16'd1;
            if (cyc >= m_ready[k] && m_pend[k] != 4'b0) begin
                sel = -1;
                for (int j = 1; j <= 4; j++) begin
                    ix = 2'((m_ptr[k] + j) % 4);
                    if (sel < 0 && m_pend[k][ix]) sel = int'(ix);
                end
                ix         = 2'(sel);
                m_pulse[k] = 1'b1;
                m_grant[k] = 4'b0001 << ix;
                m_uphdl[k] = m_dir[k][ix];
                m_ptr[k]   = sel;
                m_ready[k] = cyc + gap_of(k) + 2;
            end else begin
                m_pulse[k] = 1'b0;
                m_grant[k] = 4'b0;
                m_uphdl[k] = 1'b0;
            end
            m_pend[k] = np;
            m_dir[k]  = nd;
            m_drop[k] = ndr;
            m_busy[k] = (cyc + 1 < m_ready[k]);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_u%0d", k),
                64'({pulse_w[k], uphdl_w[k], grant_w[k], pend_w[k], drop_w[k], busy_w[k], d_ctr[k]}),
                64'({m_pulse[k], m_uphdl[k], m_grant[k], m_pend[k], m_drop[k], m_busy[k], m_ctr[k]}));
        end
    endtask

    task automatic tick(input logic [3:0] r, input logic [3:0] d);
        compare_all();
        req = r;
        dir = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        req     = '0;
        dir     = '0;
        rst     = 1'b1;
        ctr_clr = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ctr_clr = 1'b0;
        cyc++;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gs [$];
        logic       us [$];
        int         cs [$];
        logic [3:0] exp_g [4];
        logic       exp_u [4];
        int         found;
        int         g1;
        int         npulse;

        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_u = '{1'b1, 1'b0, 1'b1, 1'b0};
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b1;
        ctr_clr = 1'b1;
        req     = '0;
        dir     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        ctr_clr = 1'b0;
        model_reset();

        // reset state
        chk("reset_outs", 64'({pulse_w[0], uphdl_w[0], grant_w[0], pend_w[0], drop_w[0], busy_w[0]}), 64'd0);

        // single increment request at cycle 5, pulse in cycle 7
        repeat (5) tick(4'b0000, 4'b0000);
        tick(4'b0001, 4'b0001);
        tick(4'b0000, 4'b0000);
        chk("t1_pulse", 64'({pulse_w[0], uphdl_w[0], grant_w[0]}), 64'({1'b1, 1'b1, 4'b0001}));
        repeat (8) tick(4'b0000, 4'b0000);
        chk("t1_ctr", 64'(d_ctr[0]), 64'h0001);

        // all four at once, rotated grants spaced gap+2 apart
        do_reset();
        tick(4'b1111, 4'b0101);
        for (int w = 0; w < 25; w++) begin
            if (pulse_w[0]) begin
                gs.push_back(grant_w[0]);
                us.push_back(uphdl_w[0]);
                cs.push_back(cyc);
            end
            tick(4'b0000, 4'b0000);
        end
        chk("t2_count", 64'(gs.size()), 64'd4);
        for (int i = 0; i < gs.size() && i < 4; i++) begin
            chk($sformatf("t2_grant%0d", i), 64'(gs[i]), 64'(exp_g[i]));
            chk($sformatf("t2_uphdl%0d", i), 64'(us[i]), 64'(exp_u[i]));
            if (i > 0) chk($sformatf("t2_space%0d", i), 64'(cs[i] - cs[i-1]), 64'd5);
        end

        // second request while pending and ungranted is dropped
        npulse = 0;
        tick(4'b0100, 4'b0100);
        tick(4'b0100, 4'b0100);
        for (int w = 0; w < 10; w++) begin
            if (pulse_w[0]) npulse++;
            tick(4'b0000, 4'b0000);
        end
        chk("t3_pulses", 64'(npulse), 64'd1);
        chk("t3_drop", 64'(drop_w[0]), 64'b0100);

        // request in the grant cycle re-arms without a drop
        tick(4'b0010, 4'b0010);
        found = 0;
        for (int w = 0; w < 10 && found == 0; w++) begin
            if (grant_w[0][1]) found = 1;
            else tick(4'b0000, 4'b0000);
        end
        chk("t4_grant_seen", 64'(found), 64'd1);
        if (found == 1) begin
            g1 = cyc;
            tick(4'b0010, 4'b0000);
            chk("t4_pend", 64'(pend_w[0][1]), 64'd1);
            found = 0;
            for (int w = 0; w < 20 && found == 0; w++) begin
                if (pulse_w[0]) found = 1;
                else tick(4'b0000, 4'b0000);
            end
            chk("t4_second_seen", 64'(found), 64'd1);
            chk("t4_space", 64'(cyc - g1), 64'd5);
            chk("t4_uphdl", 64'(uphdl_w[0]), 64'd0);
            chk("t4_nodrop", 64'(drop_w[0][1]), 64'd0);
            chk("t3_drop_sticky", 64'(drop_w[0]), 64'b0100);
        end
        repeat (8) tick(4'b0000, 4'b0000);

        // asynchronous reset during the gap
        do_reset();
        tick(4'b1011, 4'b1111);
        tick(4'b0000, 4'b0000);
        chk("t5_issue", 64'({pulse_w[0], grant_w[0]}), 64'({1'b1, 4'b0001}));
        tick(4'b0000, 4'b0000);
        chk("t5_gap", 64'({busy_w[0], pulse_w[0], pend_w[0]}), 64'({1'b1, 1'b0, 4'b1010}));
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t5_async_u%0d", k),
                64'({pulse_w[k], uphdl_w[k], grant_w[k], pend_w[k], drop_w[k], busy_w[k]}), 64'd0);
        end
        do_reset();
        npulse = 0;
        for (int w = 0; w < 12; w++) begin
            if (pulse_w[0] || pulse_w[1]) npulse++;
            tick(4'b0000, 4'b0000);
        end
        chk("t5_quiet", 64'(npulse), 64'd0);

        // held decrement request, gap 0: pulse every 2 cycles, first step wraps
        do_reset();
        npulse = 0;
        for (int w = 0; w < 100; w++) begin
            if (pulse_w[1]) npulse++;
            if (w == 3) chk("t6_wrap", 64'(d_ctr[1]), 64'hFFFF);
            tick(4'b0001, 4'b0000);
        end
        chk("t6_pulses", 64'(npulse), 64'd49);
        repeat (8) tick(4'b0000, 4'b0000);

        // random sparse requests
        do_reset();
        for (int w = 0; w < 400; w++) begin
            tick(4'($urandom & $urandom), 4'($urandom));
        end
        repeat (20) tick(4'b0000, 4'b0000);
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
